oled_spi_driver: RTL and testbench

- Downstream display stage for the image controller.
- Powers up and initialises an SSD1306 128x64 OLED over 4-wire SPI, then streams frames to it continuously.
- Each frame is 1024 bytes; the block drives `byte_counter` to the image controller and serialises the byte that comes back on `data_in`.
- Each frame starts with an address-window command sequence, and the block pulses `frame_done` after the last byte of every frame.

---
 rtl/oled_pkg.sv | 19 +
 rtl/oled_spi_driver_spi_byte_tx.sv | 86 ++++++++
 rtl/oled_spi_driver.sv | 137 +++++++++++++
 tb/tb_oled_spi_driver.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// SSD1306 command tables, frame geometry and sequencer state encodings.
package oled_pkg;
  localparam int INIT_LEN = 25;
  localparam int ADDR_LEN = 6;
  localparam int FB_BYTES = 1024;

  localparam logic [7:0] INIT_ROM [0:INIT_LEN-1] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
    8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
    8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
  };

  localparam logic [7:0] ADDR_ROM [0:ADDR_LEN-1] = '{
    8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07
  };

  typedef enum logic [2:0] {RST_LOW, RST_WAIT, INIT, ADDR, PIXEL} state_e;
  typedef enum logic [1:0] {FETCH0, FETCH1, XFER} xfer_e;
endpackage

// File: rtl/oled_spi_driver_spi_byte_tx.sv
// SPI mode-0 byte shifter: 8 bits MSB first with CS low, then a CS-high gap.
// done pulses in the last gap cycle; start is ignored unless idle.
module spi_byte_tx #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       done,
  output logic       sclk,
  output logic       mosi,
  output logic       cs
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH, GAP} phase_e;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  phase_e        phase_q, phase_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          div_end;

  assign div_end = (div_q == DW'(CLK_DIV - 1));

  always_comb begin
    phase_d = phase_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    done    = 1'b0;
    case (phase_q)
      IDLE: if (start) begin
        phase_d = LOW;
        shift_d = byte_in;
        div_d   = '0;
        bit_d   = '0;
      end
      LOW: if (div_end) begin
        div_d   = '0;
        phase_d = HIGH;
      end else begin
        div_d = div_q + 1'b1;
      end
      HIGH: if (div_end) begin
        div_d = '0;
        if (bit_q == 3'd7) begin
          phase_d = GAP;
        end else begin
          // next bit appears on MOSI as SCLK falls
          phase_d = LOW;
          bit_d   = bit_q + 3'd1;
          shift_d = {shift_q[6:0], 1'b0};
        end
      end else begin
        div_d = div_q + 1'b1;
      end
      GAP: if (div_end) begin
        div_d   = '0;
        phase_d = IDLE;
        done    = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
      default: phase_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      phase_q <= phase_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  assign cs   = !((phase_q == LOW) || (phase_q == HIGH));
  assign sclk = (phase_q == HIGH);
  assign mosi = !cs && shift_q[7];
endmodule

// File: rtl/oled_spi_driver.sv
// SSD1306 power-up, init and continuous frame streaming over 4-wire SPI.
// Each byte: 2 fetch cycles then the SPI shifter; byte_counter feeds the image source.
module oled_spi_driver
  import oled_pkg::*;
#(
  parameter int CLK_DIV      = 2,
  parameter int RESET_CYCLES = 1000,
  parameter int RESET_WAIT   = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  output logic [9:0] byte_counter,
  output logic       oled_sclk,
  output logic       oled_mosi,
  output logic       oled_cs,
  output logic       oled_dc,
  output logic       oled_res,
  output logic       frame_done
);
  // The first INIT fetch overlaps the tail of the wait, so CS falls RESET_WAIT cycles after RES rises.
  localparam int WAIT_LAST = (RESET_WAIT >= 3) ? RESET_WAIT - 3 : 0;

  state_e      seq_q, seq_d;
  xfer_e       xfer_q, xfer_d;
  logic [31:0] cnt_q, cnt_d;
  logic [4:0]  idx_q, idx_d;
  logic [9:0]  bc_q, bc_d;
  logic        frame_done_q, frame_done_d;
  logic        tx_start, tx_done;
  logic [7:0]  tx_byte;

  always_comb begin
    seq_d        = seq_q;
    xfer_d       = xfer_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    bc_d         = bc_q;
    frame_done_d = 1'b0;
    tx_start     = 1'b0;
    case (seq_q)
      RST_LOW: if (cnt_q == 32'(RESET_CYCLES - 1)) begin
        cnt_d = '0;
        seq_d = RST_WAIT;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
      RST_WAIT: if (cnt_q == 32'(WAIT_LAST)) begin
        cnt_d  = '0;
        seq_d  = INIT;
        xfer_d = FETCH0;
        idx_d  = '0;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
      default: begin
        case (xfer_q)
          FETCH0: xfer_d = FETCH1;
          FETCH1: begin
            tx_start = 1'b1;
            xfer_d   = XFER;
          end
          default: if (tx_done) begin
            xfer_d = FETCH0;
            case (seq_q)
              INIT: if (idx_q == 5'(INIT_LEN - 1)) begin
                idx_d = '0;
                seq_d = ADDR;
              end else begin
                idx_d = idx_q + 5'd1;
              end
              ADDR: if (idx_q == 5'(ADDR_LEN - 1)) begin
                idx_d = '0;
                seq_d = PIXEL;
              end else begin
                idx_d = idx_q + 5'd1;
              end
              default: if (bc_q == 10'(FB_BYTES - 1)) begin
                bc_d         = '0;
                frame_done_d = 1'b1;
                seq_d        = ADDR;
              end else begin
                bc_d = bc_q + 10'd1;
              end
            endcase
          end
        endcase
      end
    endcase
  end

  // The shifter loads tx_byte on the edge ending FETCH1, which is the data_in capture point.
  always_comb begin
    tx_byte = 8'h00;
    case (seq_q)
      INIT:    tx_byte = INIT_ROM[idx_q];
      ADDR:    tx_byte = ADDR_ROM[idx_q];
      PIXEL:   tx_byte = data_in;
      default: tx_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_q        <= RST_LOW;
      xfer_q       <= FETCH0;
      cnt_q        <= '0;
      idx_q        <= '0;
      bc_q         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      seq_q        <= seq_d;
      xfer_q       <= xfer_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      bc_q         <= bc_d;
      frame_done_q <= frame_done_d;
    end
  end

  spi_byte_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (tx_start),
    .byte_in (tx_byte),
    .done    (tx_done),
    .sclk    (oled_sclk),
    .mosi    (oled_mosi),
    .cs      (oled_cs)
  );

  // Sequencer state only moves at the end of a gap, so DC never toggles with CS low.
  assign oled_dc      = (seq_q == PIXEL);
  assign oled_res     = (seq_q != RST_LOW);
  assign byte_counter = bc_q;
  assign frame_done   = frame_done_q;
endmodule

// File: tb/tb_oled_spi_driver.sv
// Bench for oled_spi_driver: two instances run side by side, one streams two frames,
// the other takes a reset in the middle of pixel byte 500.
`timescale 1ns/1ps
module tb_oled_spi_driver;
  localparam int CD = 2;
  localparam int RC = 20;
  localparam int RW = 12;
  localparam int BP = 2 + 17 * CD;

  logic       clk;
  logic [1:0] rst_n;
  logic [1:0] cs, sclk, mosi, dc, res, fd;
  logic [9:0] bc  [2];
  logic [7:0] din [2];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    oled_spi_driver #(.CLK_DIV(CD), .RESET_CYCLES(RC), .RESET_WAIT(RW)) dut (
      .clk          (clk),
      .rst_n        (rst_n[g]),
      .data_in      (din[g]),
      .byte_counter (bc[g]),
      .oled_sclk    (sclk[g]),
      .oled_mosi    (mosi[g]),
      .oled_cs      (cs[g]),
      .oled_dc      (dc[g]),
      .oled_res     (res[g]),
      .frame_done   (fd[g])
    );
  end

  function automatic logic [7:0] img(input logic [9:0] k);
    return k[7:0] ^ {k[9:8], 6'b0};
  endfunction

  // Registered image source; scrambled while CS is low so an unlatched byte would show.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      din[i] <= cs[i] ? img(bc[i]) : (img(bc[i]) ^ 8'hA5);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // SPI decoder and protocol monitor
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [1:0] cs_p = 2'b11, sclk_p = 2'b00, dc_p = 2'b00;
  int         rises [2] = '{0, 0};
  logic [7:0] sh [2];
  int         v_dc [2] = '{0, 0};
  int         v_sclk [2] = '{0, 0};
  int         v_edges [2] = '{0, 0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!cs[i] && dc[i] !== dc_p[i]) v_dc[i]++;
      if (cs[i] && sclk[i]) v_sclk[i]++;
      if (!cs[i] && sclk[i] && !sclk_p[i]) begin
        rises[i]++;
        sh[i] = {sh[i][6:0], mosi[i]};
      end
      if (cs[i] && !cs_p[i]) begin
        if (rst_n[i]) begin
          if (rises[i] != 8) v_edges[i]++;
          if (i == 0) q0.push_back({dc_p[i], sh[i]});
          else        q1.push_back({dc_p[i], sh[i]});
        end
        rises[i] = 0;
      end
    end
    cs_p   = cs;
    sclk_p = sclk;
    dc_p   = dc;
  end

  typedef struct {
    string      name;
    int         pos;
    logic [8:0] exp;
  } vec_t;
  localparam int NV = 31 + 6 + 13;
  vec_t       vecs [NV];
  logic [7:0] cmd_exp [0:30];

  task automatic set_vec(input int idx, input string name, input int pos, input logic [8:0] exp);
    vecs[idx].name = name;
    vecs[idx].pos  = pos;
    vecs[idx].exp  = exp;
  endtask

  int ta_t, ta_np, ta_tcs, fdc0, fdc1, ta_mis;
  int tb_t, tb_r, tb_base;
  logic tb_prev;
  logic [8:0] got;

  initial begin
    cmd_exp = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
                8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
                8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF,
                8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};
    for (int i = 0; i < 31; i++) set_vec(i, $sformatf("cmd%0d", i), i, {1'b0, cmd_exp[i]});
    for (int i = 0; i < 6; i++)  set_vec(31 + i, $sformatf("f2_addr%0d", i), 1055 + i, {1'b0, cmd_exp[25 + i]});
    set_vec(37, "f1_px0",    31 + 0,    9'h100);
    set_vec(38, "f1_px1",    31 + 1,    9'h101);
    set_vec(39, "f1_px2",    31 + 2,    9'h102);
    set_vec(40, "f1_px255",  31 + 255,  9'h1FF);
    set_vec(41, "f1_px256",  31 + 256,  9'h140);
    set_vec(42, "f1_px511",  31 + 511,  9'h1BF);
    set_vec(43, "f1_px512",  31 + 512,  9'h180);
    set_vec(44, "f1_px767",  31 + 767,  9'h17F);
    set_vec(45, "f1_px768",  31 + 768,  9'h1C0);
    set_vec(46, "f1_px1022", 31 + 1022, 9'h13E);
    set_vec(47, "f1_px1023", 31 + 1023, 9'h13F);
    set_vec(48, "f2_px0",    1061 + 0,    9'h100);
    set_vec(49, "f2_px1023", 1061 + 1023, 9'h13F);

    rst_n = 2'b00;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst%0d_bc", i),   32'(bc[i]), 0);
      chk($sformatf("rst%0d_cs", i),   32'(cs[i]), 1);
      chk($sformatf("rst%0d_sclk", i), 32'(sclk[i]), 0);
      chk($sformatf("rst%0d_mosi", i), 32'(mosi[i]), 0);
      chk($sformatf("rst%0d_dc", i),   32'(dc[i]), 0);
      chk($sformatf("rst%0d_res", i),  32'(res[i]), 0);
      chk($sformatf("rst%0d_fd", i),   32'(fd[i]), 0);
    end
    rst_n = 2'b11;

    fork
      begin : thr_a
        ta_t = 0;
        while (!res[0] && ta_t < RC + 100) begin @(negedge clk); ta_t++; end
        chk("res_low_cycles", 32'(ta_t), RC);
        ta_t = 0;
        while (cs[0] && ta_t < RW + 100) begin @(negedge clk); ta_t++; end
        chk("cs_first_fall", 32'(ta_t), RW);
        ta_tcs = cyc;
        ta_np = 0; ta_t = 0; fdc0 = 0; fdc1 = 0;
        while (ta_np < 2 && ta_t < 80000) begin
          @(negedge clk); ta_t++;
          if (fd[0]) begin
            if (ta_np == 0) fdc0 = cyc; else fdc1 = cyc;
            chk($sformatf("fd%0d_bc_wrap", ta_np), 32'(bc[0]), 0);
            if (ta_np == 1) chk("q0_len_at_fd2", 32'(q0.size()), 2085);
            ta_np++;
            @(negedge clk); ta_t++;
            chk("fd_width", 32'(fd[0]), 0);
          end
        end
        chk("fd_count", 32'(ta_np), 2);
        chk("fd_first_latency", 32'(fdc0 - ta_tcs), 32'(1055 * BP - 2));
        chk("fd_period", 32'(fdc1 - fdc0), 32'(1030 * BP));
        for (int i = 0; i < NV; i++) begin
          got = (vecs[i].pos < q0.size()) ? q0[vecs[i].pos] : 9'h1XX;
          chk(vecs[i].name, 32'(got), 32'(vecs[i].exp));
        end
        for (int f = 0; f < 2; f++) begin
          ta_mis = 0;
          for (int k = 0; k < 1024; k++) begin
            if (31 + f * 1030 + k >= q0.size()) ta_mis++;
            else if (q0[31 + f * 1030 + k] !== {1'b1, img(10'(k))}) ta_mis++;
          end
          chk($sformatf("frame%0d_pixel_mismatches", f + 1), 32'(ta_mis), 0);
        end
      end
      begin : thr_b
        tb_t = 0;
        while (bc[1] != 10'd500 && tb_t < 40000) begin @(negedge clk); tb_t++; end
        chk("b_reach_500", 32'(bc[1]), 500);
        tb_t = 0;
        while (cs[1] && tb_t < 100) begin @(negedge clk); tb_t++; end
        tb_r = 0; tb_prev = 1'b0;
        while (tb_r < 3 && tb_t < 300) begin
          @(negedge clk); tb_t++;
          if (sclk[1] && !tb_prev) tb_r++;
          tb_prev = sclk[1];
        end
        while (sclk[1] && tb_t < 300) begin @(negedge clk); tb_t++; end
        chk("b_bytes_before_reset", 32'(q1.size()), 531);
        chk("b_cs_low_at_bit3", 32'(cs[1]), 0);
        rst_n[1] = 1'b0;
        #1;
        chk("b_abort_cs", 32'(cs[1]), 1);
        chk("b_abort_bc", 32'(bc[1]), 0);
        chk("b_abort_sclk", 32'(sclk[1]), 0);
        chk("b_abort_res", 32'(res[1]), 0);
        chk("b_abort_dc", 32'(dc[1]), 0);
        repeat (3) @(negedge clk);
        tb_base = q1.size();
        chk("b_no_partial_byte", 32'(tb_base), 531);
        rst_n[1] = 1'b1;
        tb_t = 0;
        while (!res[1] && tb_t < RC + 100) begin @(negedge clk); tb_t++; end
        chk("b_res_low_again", 32'(tb_t), RC);
        tb_t = 0;
        while (q1.size() < tb_base + 31 && tb_t < 40 * BP) begin @(negedge clk); tb_t++; end
        for (int i = 0; i < 31; i++) begin
          got = (tb_base + i < q1.size()) ? q1[tb_base + i] : 9'h1XX;
          chk($sformatf("b_reinit%0d", i), 32'(got), 32'({1'b0, cmd_exp[i]}));
        end
      end
    join

    for (int i = 0; i < 2; i++) begin
      chk($sformatf("dut%0d_dc_change_cs_low", i), 32'(v_dc[i]), 0);
      chk($sformatf("dut%0d_sclk_high_cs_high", i), 32'(v_sclk[i]), 0);
      chk($sformatf("dut%0d_windows_not_8_edges", i), 32'(v_edges[i]), 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
